// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifu_state_e;

    localparam int unsigned FETCH_BYTES = 8;
    localparam int unsigned INST_BYTES  = 4;

    localparam logic [63:0] ALIGN8_MASK = ~64'(FETCH_BYTES - 1);
    localparam logic [63:0] ALIGN4_MASK = ~64'(INST_BYTES - 1);

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; flush beats push, simultaneous push and pop allowed.
module ifu_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching instruction-fetch unit: one outstanding 64-bit read, DEPTH-beat buffer.
// Optional performance counters enabled by defining IFU_PREFETCH_PERF_EN.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     FETCH_W  = 64,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [PC_W-1:0]    mem_req_addr_o,
    input  logic               mem_resp_valid_i,
    input  logic [FETCH_W-1:0] mem_resp_data_i,
    input  logic               redirect_valid_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_o,
    output logic [PC_W-1:0]    inst_pc_o
`ifdef IFU_PREFETCH_PERF_EN
    ,
    output logic [63:0]        perf_fetch_cnt_o,
    output logic [63:0]        perf_inst_cnt_o,
    output logic [63:0]        perf_flush_cnt_o
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] Mask8 = ALIGN8_MASK[PC_W-1:0];
    localparam logic [PC_W-1:0] Mask4 = ALIGN4_MASK[PC_W-1:0];

    ifu_state_e       state_q, state_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;
    logic [PC_W-1:0]  addr_q, addr_d;
    logic             stale_q, stale_d;
    logic             push, pop, flush, inst_fire;
    logic [FETCH_W-1:0] head;
    logic [CntW-1:0]  count, count_after;
    logic             empty, full;

    ifu_fifo #(
        .WIDTH (FETCH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (mem_resp_data_i),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    assign inst_fire = !empty && inst_ready_i;

    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        out_pc_d    = out_pc_q;
        addr_d      = addr_q;
        stale_d     = stale_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        count_after = count;

        if (inst_fire) begin
            out_pc_d = out_pc_q + PC_W'(INST_BYTES);
            pop      = out_pc_q[2];
        end

        unique case (state_q)
            IDLE: if (count < CntW'(DEPTH)) state_d = REQ;
            REQ: begin
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                    // A stale request was issued for an abandoned stream; it must not advance req_pc.
                    if (!stale_q) req_pc_d = req_pc_q + PC_W'(FETCH_BYTES);
                end
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    push        = !stale_q;
                    stale_d     = 1'b0;
                    count_after = count + CntW'(push) - CntW'(pop);
                    state_d     = (count_after < CntW'(DEPTH)) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid_i) begin
            flush    = 1'b1;
            push     = 1'b0;
            pop      = 1'b0;
            out_pc_d = redirect_pc_i & Mask4;
            req_pc_d = redirect_pc_i & Mask8;
            unique case (state_q)
                IDLE: state_d = IDLE;
                REQ: begin
                    state_d = mem_req_ready_i ? WAIT : REQ;
                    stale_d = 1'b1;
                end
                WAIT: begin
                    // A response landing this very cycle is simply dropped; nothing remains outstanding.
                    state_d = mem_resp_valid_i ? IDLE : WAIT;
                    stale_d = !mem_resp_valid_i;
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_q != REQ && state_d == REQ) addr_d = req_pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_pc_q <= RESET_PC & Mask8;
            out_pc_q <= RESET_PC;
            addr_q   <= RESET_PC & Mask8;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            out_pc_q <= out_pc_d;
            addr_q   <= addr_d;
            stale_q  <= stale_d;
        end
    end

    assign mem_req_valid_o = (state_q == REQ);
    assign mem_req_addr_o  = addr_q;
    assign inst_valid_o    = !empty;
    assign inst_o          = empty ? 32'h0 : (out_pc_q[2] ? head[63:32] : head[31:0]);
    assign inst_pc_o       = out_pc_q;

`ifdef IFU_PREFETCH_PERF_EN
    logic [63:0] fetch_cnt_q, inst_cnt_q, flush_cnt_q;
    logic        flush_event;

    assign flush_event = redirect_valid_i && (!empty || state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            inst_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (mem_req_valid_o && mem_req_ready_i && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + 64'd1;
            if (inst_fire && !redirect_valid_i && inst_cnt_q != '1)
                inst_cnt_q <= inst_cnt_q + 64'd1;
            if (flush_event && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 64'd1;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_inst_cnt_o  = inst_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed scenarios plus a randomized stream check.
module tb_ifu_prefetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid_o;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid_o;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
`ifdef IFU_PREFETCH_PERF_EN
    logic [63:0] perf_fetch_cnt_o, perf_inst_cnt_o, perf_flush_cnt_o;
`endif

    ifu_prefetch #(
        .PC_W     (32),
        .FETCH_W  (64),
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_data_i  (mem_resp_data),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o)
`ifdef IFU_PREFETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_inst_cnt_o  (perf_inst_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    initial forever #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc = RESET_PC;
    int          accept_cnt = 0;
    logic [31:0] acc_last = '0;
    logic        pending = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_lat = 0;
    int          lat_min = 0;
    int          lat_max = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        if (a == 32'h8000_0004) return 32'h0000_0013;
        return {a[15:0] ^ 16'hA5C3, a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: records accepted requests, answers each one after a random delay.
    initial forever begin
        @(posedge clk);
        if (!rst && mem_req_valid_o && mem_req_ready) begin
            pending    = 1'b1;
            pend_addr  = mem_req_addr_o;
            pend_lat   = int'($urandom_range(lat_max, lat_min));
            accept_cnt++;
            acc_last   = mem_req_addr_o;
        end
    end

    initial forever begin
        @(negedge clk);
        mem_resp_valid = 1'b0;
        if (pending) begin
            if (pend_lat == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = {word_at(pend_addr + 32'd4), word_at(pend_addr)};
                pending        = 1'b0;
            end else begin
                pend_lat--;
            end
        end
    end

    // Reference: decode sees PCs advancing by 4 from the last target, word = memory at that PC.
    task automatic tick();
        if (!rst) begin
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (inst_valid_o && inst_ready) begin
                check("inst_pc", inst_pc_o, exp_pc);
                check("inst", inst_o, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (mem_req_valid_o) check("req_align", mem_req_addr_o[2:0], 0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 20 && pending; k++) tick();
        tick();
        accept_cnt = 0;
        rst        = 1'b0;
        exp_pc     = RESET_PC;
    endtask

    initial begin
        logic [31:0] a0;
        logic        prev_redir;

        @(negedge clk);
        do_reset();
        rst = 1'b1;
        tick();
        check("rst_req_valid", mem_req_valid_o, 0);
        check("rst_req_addr", mem_req_addr_o, 32'h8000_0000);
        check("rst_inst_valid", inst_valid_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_inst_pc", inst_pc_o, RESET_PC);

        // Basic fetch after reset release
        rst = 1'b0;
        mem_req_ready = 1'b1;
        lat_min = 0;
        lat_max = 0;
        tick();
        check("first_req_valid", mem_req_valid_o, 1);
        check("first_req_addr", mem_req_addr_o, 32'h8000_0000);
        tick();
        check("no_inst_before_resp", inst_valid_o, 0);
        tick();
        check("inst_valid_after_resp", inst_valid_o, 1);
        check("inst0", inst_o, 32'h0010_0093);
        check("inst0_pc", inst_pc_o, 32'h8000_0000);
        check("req1_valid", mem_req_valid_o, 1);
        check("req1_addr", mem_req_addr_o, 32'h8000_0008);
        inst_ready = 1'b1;
        tick();
        check("inst1", inst_o, 32'h0000_0013);
        check("inst1_pc", inst_pc_o, 32'h8000_0004);

        // Back-pressure: exactly DEPTH fetches, then idle; drain with no gap
        do_reset();
        mem_req_ready = 1'b1;
        repeat (40) tick();
        check("bp_accepts", accept_cnt, 4);
        check("bp_req_idle", mem_req_valid_o, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_no_gap", inst_valid_o, 1);
            tick();
        end

        // Redirect while waiting on a response
        do_reset();
        mem_req_ready = 1'b1;
        lat_min = 5;
        lat_max = 5;
        for (int k = 0; k < 20 && accept_cnt < 1; k++) tick();
        check("w_first_accept", accept_cnt, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0104;
        lat_min = 0;
        lat_max = 0;
        tick();
        redirect_valid = 1'b0;
        check("w_flush_valid", inst_valid_o, 0);
        for (int k = 0; k < 30 && accept_cnt < 2; k++) tick();
        check("w_second_accept", accept_cnt, 2);
        check("w_new_addr", acc_last, 32'h8000_0100);
        inst_ready = 1'b1;
        for (int k = 0; k < 30 && !inst_valid_o; k++) tick();
        check("w_valid", inst_valid_o, 1);
        check("w_first_pc", inst_pc_o, 32'h8000_0104);
        check("w_first_inst", inst_o, word_at(32'h8000_0104));

        // Redirect while a request is stalled
        do_reset();
        for (int k = 0; k < 5 && !mem_req_valid_o; k++) tick();
        check("s_req_valid", mem_req_valid_o, 1);
        a0 = mem_req_addr_o;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0208;
        tick();
        redirect_valid = 1'b0;
        repeat (2) begin
            check("s_valid_held", mem_req_valid_o, 1);
            check("s_addr_held", mem_req_addr_o, a0);
            tick();
        end
        mem_req_ready = 1'b1;
        for (int k = 0; k < 10 && accept_cnt < 1; k++) tick();
        check("s_old_addr", acc_last, 32'h8000_0000);
        for (int k = 0; k < 10 && accept_cnt < 2; k++) tick();
        check("s_new_addr", acc_last, 32'h8000_0208);
        inst_ready = 1'b1;
        for (int k = 0; k < 30 && !inst_valid_o; k++) tick();
        check("s_valid", inst_valid_o, 1);
        check("s_first_pc", inst_pc_o, 32'h8000_0208);

        // Redirect coincident with an instruction fire
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0306;
        tick();
        redirect_valid = 1'b0;
        check("f_valid_dropped", inst_valid_o, 0);
        check("f_out_pc", inst_pc_o, 32'h8000_0304);
        for (int k = 0; k < 30 && !inst_valid_o; k++) tick();
        check("f_resume_pc", inst_pc_o, 32'h8000_0304);

        // Randomized traffic against the stream model, including wrap-around targets
        do_reset();
        lat_min = 0;
        lat_max = 3;
        prev_redir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                prev_redir = 1'b0;
            end
            if (prev_redir) check("rnd_flush", inst_valid_o, 0);
            mem_req_ready = ($urandom_range(3, 0) != 0);
            inst_ready    = ($urandom_range(2, 0) != 0);
            if ($urandom_range(99, 0) < 4) begin
                redirect_valid = 1'b1;
                if ($urandom_range(1, 0) == 1)
                    redirect_pc = 32'h8000_0000 + ($urandom_range(1023, 0) << 2)
                                  + $urandom_range(3, 0);
                else
                    redirect_pc = 32'hFFFF_FFE0 + $urandom_range(31, 0);
            end else begin
                redirect_valid = 1'b0;
            end
            prev_redir = redirect_valid;
            tick();
        end
        redirect_valid = 1'b0;

`ifdef IFU_PREFETCH_PERF_EN
        do_reset();
        lat_min = 0;
        lat_max = 0;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 40 && accept_cnt < 3; k++) tick();
        mem_req_ready = 1'b0;
        repeat (4) tick();
        inst_ready = 1'b1;
        repeat (5) tick();
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        tick();
        redirect_valid = 1'b0;
        check("perf_fetch", perf_fetch_cnt_o, 3);
        check("perf_inst", perf_inst_cnt_o, 5);
        check("perf_flush", perf_flush_cnt_o, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction-fetch unit replacing the core top's combinational, per-cycle doubleword fetch.
- Issues aligned FETCH_W-bit read requests over a valid/ready memory port, one request in flight at a time.
- Buffers returned doublewords in a DEPTH-entry prefetch FIFO and hands 32-bit instructions plus their PCs to decode over a valid/ready port.
- Handles branch/jal/jalr redirects by flushing the FIFO and discarding any stale in-flight response.

Parameters:
- PC_W, 32, PC and memory address width.
- FETCH_W, 64, memory data width in bits. Must be 64: two instructions per beat.
- DEPTH, 4, prefetch FIFO entries. Power of two, ≥2.
- RESET_PC, 32'h8000_0000, first fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high.
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  PC_W  request address. 8-byte aligned; bits [2:0] always 0.
- mem_resp_valid  in  1  read data valid. Always ≥1 cycle after request accept. Never back-pressured.
- mem_resp_data  in  FETCH_W  read data
- redirect_valid  in  1  control-flow change from execute
- redirect_pc  in  PC_W  new PC. Bits [1:0] are forced to 0 internally.
- inst_valid  out  1  instruction available
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  PC_W  PC of inst

Behaviour:
- Reset values:
  - mem_req_valid=0, mem_req_addr=RESET_PC&~7, inst_valid=0, inst=0, inst_pc=RESET_PC.
  - FIFO empty, state IDLE, stale=0.
- Registers:
  - req_pc: next aligned fetch address.
  - out_pc: PC of the FIFO head instruction.
- State machine, states IDLE/REQ/WAIT:
  - IDLE→REQ when occupancy < DEPTH. mem_req_valid is asserted in REQ.
  - REQ: mem_req_valid=1 and mem_req_addr held stable until mem_req_ready. On accept, go to WAIT and set req_pc += 8.
  - WAIT: on mem_resp_valid, push {data} into the FIFO unless stale. Clear stale, then go to IDLE, or straight to REQ if occupancy after the push is < DEPTH.
- Occupancy and issue:
  - A slot is reserved at request accept, so the FIFO never overflows.
  - A push is dropped only when stale=1.
- Output:
  - inst_valid = FIFO non-empty.
  - inst = out_pc[2] ? head[63:32] : head[31:0].
  - inst_pc = out_pc.
  - On fire (inst_valid & inst_ready), out_pc += 4. The head is popped when out_pc[2]==1.
- Redirect (highest priority; overrides fire, push and the state transition in the same cycle):
  - FIFO flushed.
  - out_pc <= redirect_pc & ~3.
  - req_pc <= redirect_pc & ~7.
  - In WAIT, or in REQ with the request accepted this cycle: stale <= 1.
  - In REQ not yet accepted: request stays asserted with its old address (stable-address rule), and stale is set so its response is discarded.
  - inst_valid=0 on the next cycle.
- Redirect with redirect_pc[2]=1: the first beat's lower half is skipped through out_pc[2]=1.
- Latency:
  - mem_req_valid rises on the first cycle after rst falls.
  - inst_valid rises on the cycle after mem_resp_valid.
- Wrap-around: req_pc and out_pc wrap modulo 2^PC_W.
- Reset mid-operation clears everything. A response arriving after reset with nothing outstanding is ignored.

Optional Feature:
- Macro: IFU_PREFETCH_PERF_EN.
- When defined: adds outputs perf_fetch_cnt (64), perf_inst_cnt (64) and perf_flush_cnt (64).
  - perf_fetch_cnt increments on each request accept.
  - perf_inst_cnt increments on each instruction fire.
  - perf_flush_cnt increments on each redirect that discards a non-empty FIFO or a stale response.
  - All three reset to 0 and saturate at all-ones.
- When undefined: the ports and logic are absent, with identical functional behaviour.

Decomposition:
- Package ifu_pkg:
  - State enum IDLE/REQ/WAIT (2 bits).
  - FETCH_BYTES=8.
  - INST_BYTES=4.
  - ALIGN8_MASK and ALIGN4_MASK constants.
- Sub-module ifu_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Interfaces: push/pop/flush, count, empty/full.
  - Same-cycle push+pop is allowed.
  - Flush has priority over push.

Test Plan:
- Reset release, memory returns 0x00000013_00100093 at 0x80000000: req addr 0x80000000, then inst 0x00100093 @0x80000000, then 0x00000013 @0x80000004, then a request to 0x80000008.
- inst_ready held 0: exactly DEPTH=4 requests are accepted, then mem_req_valid stays 0. Releasing inst_ready produces 8 sequential instructions with no gap.
- Redirect to 0x80000104 while in WAIT: the old response is discarded; next request addr 0x80000100; first inst_pc=0x80000104 (upper half).
- Redirect while mem_req_valid=1 and mem_req_ready=0: addr stays stable until accepted; that response is dropped; the following request uses the new aligned addr.
- Redirect and inst fire in the same cycle: redirect wins; inst_valid=0 next cycle; out_pc=redirect target.
- With IFU_PREFETCH_PERF_EN: 3 fetches, 5 instructions and 1 flushing redirect give counters 3/5/1.
